// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb game sequencer and its strike counter.
package bomb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_ARMED,
    ST_EXPLODED,
    ST_DEFUSED
  } state_t;

  localparam logic [1:0] VERSION_A = 2'd0;
  localparam logic [1:0] VERSION_B = 2'd1;
  localparam logic [1:0] VERSION_C = 2'd2;
  localparam logic [1:0] VERSION_D = 2'd3;

  localparam int STRIKE_W = 3;

endpackage

// File: rtl/bomb_sequencer_if.sv
// Bus between the sequencer and the puzzle modules: RNG handshake, strikes, defuse, enables, versions.
interface bomb_sequencer_if #(
  parameter int NUM_MODULES = 4
);
  logic                     rng_enable;
  logic [3:0]               rng_output;
  logic [NUM_MODULES-1:0]   strike_in;
  logic [NUM_MODULES-1:0]   defused_in;
  logic                     module_reset;
  logic [NUM_MODULES-1:0]   module_enable;
  logic [2*NUM_MODULES-1:0] version_out;

  modport master (
    output rng_enable, module_reset, module_enable, version_out,
    input  rng_output, strike_in, defused_in
  );

  modport slave (
    input  rng_enable, module_reset, module_enable, version_out,
    output rng_output, strike_in, defused_in
  );
endinterface

// File: rtl/strike_counter.sv
// Rising-edge strike detector with popcount and saturating accumulator.
module strike_counter
  import bomb_pkg::*;
#(
  parameter int NUM_MODULES = 4,
  parameter int MAX_STRIKES = 3
) (
  input  logic                   clock_65mhz,
  input  logic                   reset_n,
  input  logic [NUM_MODULES-1:0] strike_in,
  input  logic                   count_enable,
  input  logic                   clear,
  output logic [STRIKE_W-1:0]    count_next,
  output logic [STRIKE_W-1:0]    count
);

  logic [NUM_MODULES-1:0] strike_prev;
  logic [NUM_MODULES-1:0] strike_rise;
  logic [3:0]             events;
  logic [3:0]             total;

  assign strike_rise = strike_in & ~strike_prev;

  always_comb begin
    events = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      events = events + {3'b000, strike_rise[i]};
    end
    total      = {1'b0, count} + events;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      count_next = (total >= 4'(MAX_STRIKES)) ? STRIKE_W'(MAX_STRIKES) : total[STRIKE_W-1:0];
    end
  end

  // Edge history runs in every state so a strike held across arming is not counted.
  always_ff @(posedge clock_65mhz) begin
    if (!reset_n) begin
      strike_prev <= '0;
      count       <= '0;
    end else begin
      strike_prev <= strike_in;
      count       <= count_next;
    end
  end

endmodule

// File: rtl/bomb_sequencer.sv
// Game sequencer: seeds module versions from the RNG, arms the modules, runs the countdown
// and strike total, and reports exploded or defused.
//   state       | meaning
//   ST_IDLE     | modules held in reset, waiting for start
//   ST_SEED     | two cycles per module: RNG request, then version latch
//   ST_ARMED    | modules enabled, countdown and strikes live
//   ST_EXPLODED | strike limit or timeout reached, values frozen
//   ST_DEFUSED  | every module defused, values frozen
module bomb_sequencer
  import bomb_pkg::*;
#(
  parameter int NUM_MODULES   = 4,
  parameter int MAX_STRIKES   = 3,
  parameter int START_SECONDS = 300,
  parameter int TIMER_W       = 9
) (
  input  logic                clock_65mhz,
  input  logic                reset_n,
  input  logic                start,
  input  logic                one_hz_enable,
  bomb_sequencer_if.master    bus,
  output logic [TIMER_W-1:0]  seconds_left,
  output logic [STRIKE_W-1:0] strike_count,
  output logic                armed,
  output logic                exploded,
  output logic                defused
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_MODULES - 1);

  state_t                   state, state_nxt;
  logic [2:0]               seed_idx, seed_idx_nxt;
  logic                     seed_odd, seed_odd_nxt;
  logic [2*NUM_MODULES-1:0] version_q, version_nxt;
  logic [TIMER_W-1:0]       seconds_nxt;
  logic [STRIKE_W-1:0]      strikes_next;
  logic                     count_enable;
  logic                     count_clear;
  logic                     unused_rng_bits;

  assign unused_rng_bits = ^bus.rng_output[3:2];

  assign count_enable = (state == ST_ARMED);
  assign count_clear  = start && (state inside {ST_IDLE, ST_EXPLODED, ST_DEFUSED});

  strike_counter #(
    .NUM_MODULES (NUM_MODULES),
    .MAX_STRIKES (MAX_STRIKES)
  ) u_strike_counter (
    .clock_65mhz  (clock_65mhz),
    .reset_n      (reset_n),
    .strike_in    (bus.strike_in),
    .count_enable (count_enable),
    .clear        (count_clear),
    .count_next   (strikes_next),
    .count        (strike_count)
  );

  always_ff @(posedge clock_65mhz) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      seed_idx     <= '0;
      seed_odd     <= 1'b0;
      version_q    <= {NUM_MODULES{VERSION_A}};
      seconds_left <= TIMER_W'(START_SECONDS);
    end else begin
      state        <= state_nxt;
      seed_idx     <= seed_idx_nxt;
      seed_odd     <= seed_odd_nxt;
      version_q    <= version_nxt;
      seconds_left <= seconds_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    seed_idx_nxt = seed_idx;
    seed_odd_nxt = seed_odd;
    version_nxt  = version_q;
    seconds_nxt  = seconds_left;
    unique case (state)
      ST_IDLE, ST_EXPLODED, ST_DEFUSED: begin
        if (start) begin
          state_nxt    = ST_SEED;
          seed_idx_nxt = '0;
          seed_odd_nxt = 1'b0;
        end
      end
      ST_SEED: begin
        seed_odd_nxt = ~seed_odd;
        if (seed_odd) begin
          for (int i = 0; i < NUM_MODULES; i++) begin
            if (seed_idx == 3'(i)) version_nxt[2*i +: 2] = bus.rng_output[1:0];
          end
          if (seed_idx == LAST_IDX) begin
            state_nxt   = ST_ARMED;
            seconds_nxt = TIMER_W'(START_SECONDS);
          end else begin
            seed_idx_nxt = seed_idx + 3'd1;
          end
        end
      end
      ST_ARMED: begin
        if (one_hz_enable && seconds_left != '0) seconds_nxt = seconds_left - TIMER_W'(1);
        // Explosion takes priority over a simultaneous defuse.
        if (strikes_next == STRIKE_W'(MAX_STRIKES) || seconds_nxt == '0) begin
          state_nxt = ST_EXPLODED;
        end else if (&bus.defused_in) begin
          state_nxt = ST_DEFUSED;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.rng_enable    = (state == ST_SEED) && !seed_odd;
  assign bus.module_reset  = (state == ST_IDLE) || (state == ST_SEED);
  assign bus.module_enable = {NUM_MODULES{state == ST_ARMED}};
  assign bus.version_out   = version_q;
  assign armed             = (state == ST_ARMED);
  assign exploded          = (state == ST_EXPLODED);
  assign defused           = (state == ST_DEFUSED);

endmodule

// File: tb/tb_bomb_sequencer.sv
// Scoreboard bench for bomb_sequencer: a game-level reference model predicts every output each
// cycle; a monitor on the falling edge compares the DUT against the queued predictions.
module tb_bomb_sequencer;

  localparam int NM    = 4;
  localparam int MAXS  = 3;
  localparam int START = 300;
  localparam int TW    = 9;

  localparam int P_IDLE  = 0;
  localparam int P_SEED  = 1;
  localparam int P_ARMED = 2;
  localparam int P_EXPL  = 3;
  localparam int P_DEF   = 4;

  logic          clock_65mhz = 1'b0;
  logic          reset_n;
  logic          start;
  logic          one_hz_enable;
  logic [TW-1:0] seconds_left;
  logic [2:0]    strike_count;
  logic          armed, exploded, defused;

  bomb_sequencer_if #(.NUM_MODULES(NM)) bus ();

  bomb_sequencer #(
    .NUM_MODULES   (NM),
    .MAX_STRIKES   (MAXS),
    .START_SECONDS (START),
    .TIMER_W       (TW)
  ) dut (
    .clock_65mhz   (clock_65mhz),
    .reset_n       (reset_n),
    .start         (start),
    .one_hz_enable (one_hz_enable),
    .bus           (bus),
    .seconds_left  (seconds_left),
    .strike_count  (strike_count),
    .armed         (armed),
    .exploded      (exploded),
    .defused       (defused)
  );

  always #5 clock_65mhz = ~clock_65mhz;

  typedef struct {
    int            due;
    logic          rng_en;
    logic          mreset;
    logic [NM-1:0] men;
    logic [2*NM-1:0] ver;
    logic [TW-1:0] secs;
    logic [2:0]    strikes;
    logic          arm;
    logic          expl;
    logic          def;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [1:0] rng_seq[$];
  int         edge_cnt = 0;
  int         n_total  = 0;
  int         n_pass   = 0;

  // Reference model state: game phase, elapsed seeding cycles, versions, timer, strikes.
  int         m_phase;
  int         m_step;
  int         m_ver[NM];
  int         m_secs;
  int         m_strikes;
  logic [NM-1:0] m_prev;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  task automatic model_step();
    logic [NM-1:0] rises;
    if (!reset_n) begin
      m_phase   = P_IDLE;
      m_step    = 0;
      m_secs    = START;
      m_strikes = 0;
      m_prev    = '0;
      for (int i = 0; i < NM; i++) m_ver[i] = 0;
    end else begin
      rises  = bus.strike_in & ~m_prev;
      m_prev = bus.strike_in;
      case (m_phase)
        P_IDLE, P_EXPL, P_DEF: begin
          if (start) begin
            m_phase   = P_SEED;
            m_step    = 0;
            m_strikes = 0;
          end
        end
        P_SEED: begin
          if (m_step % 2 == 1) begin
            m_ver[m_step / 2] = int'(bus.rng_output) % 4;
            if (m_step / 2 == NM - 1) begin
              m_phase = P_ARMED;
              m_secs  = START;
            end
          end
          m_step++;
        end
        P_ARMED: begin
          if (one_hz_enable && m_secs > 0) m_secs--;
          m_strikes = m_strikes + $countones(rises);
          if (m_strikes > MAXS) m_strikes = MAXS;
          if (m_strikes == MAXS || m_secs == 0) m_phase = P_EXPL;
          else if (bus.defused_in == {NM{1'b1}}) m_phase = P_DEF;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.due     = edge_cnt + 1;
    e.rng_en  = (m_phase == P_SEED) && (m_step % 2 == 0);
    e.mreset  = (m_phase == P_IDLE) || (m_phase == P_SEED);
    e.men     = (m_phase == P_ARMED) ? {NM{1'b1}} : '0;
    for (int i = 0; i < NM; i++) e.ver[2*i +: 2] = 2'(m_ver[i]);
    e.secs    = TW'(m_secs);
    e.strikes = 3'(m_strikes);
    e.arm     = (m_phase == P_ARMED);
    e.expl    = (m_phase == P_EXPL);
    e.def     = (m_phase == P_DEF);
    sb_q.push_back(e);
    @(posedge clock_65mhz);
    edge_cnt++;
    #1;
    // The RNG answers a request by presenting a fresh value for the following latch cycle.
    if (bus.rng_enable === 1'b1) begin
      if (rng_seq.size() > 0) bus.rng_output = {2'($urandom_range(0, 3)), rng_seq.pop_front()};
      else bus.rng_output = 4'($urandom_range(0, 15));
    end
  endtask

  always @(negedge clock_65mhz) begin
    if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
      mon_e = sb_q.pop_front();
      chk("rng_enable",    32'(bus.rng_enable),    32'(mon_e.rng_en));
      chk("module_reset",  32'(bus.module_reset),  32'(mon_e.mreset));
      chk("module_enable", 32'(bus.module_enable), 32'(mon_e.men));
      chk("version_out",   32'(bus.version_out),   32'(mon_e.ver));
      chk("seconds_left",  32'(seconds_left),      32'(mon_e.secs));
      chk("strike_count",  32'(strike_count),      32'(mon_e.strikes));
      chk("armed",         32'(armed),             32'(mon_e.arm));
      chk("exploded",      32'(exploded),          32'(mon_e.expl));
      chk("defused",       32'(defused),           32'(mon_e.def));
    end
  end

  task automatic play_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int b;
    rng_seq.push_back(2'd1);
    rng_seq.push_back(2'd2);
    rng_seq.push_back(2'd3);
    rng_seq.push_back(2'd0);
    reset_n        = 1'b0;
    start          = 1'b0;
    one_hz_enable  = 1'b0;
    bus.strike_in  = '0;
    bus.defused_in = '0;
    bus.rng_output = 4'h0;
    repeat (3) tick();

    // Game 1: seeding sequence, strike held across arming, then a double strike explodes.
    reset_n       = 1'b1;
    bus.strike_in = 4'b0001;
    tick();
    play_start();
    chk("first_rng_pulse", 32'(bus.rng_enable), 32'd1);
    repeat (8) tick();
    chk("arm_plan",     32'(armed),           32'd1);
    chk("version_plan", 32'(bus.version_out), 32'h39);
    chk("seconds_plan", 32'(seconds_left),    32'd300);
    chk("held_strike",  32'(strike_count),    32'd0);
    bus.strike_in = 4'b0000; tick();
    bus.strike_in = 4'b0001; tick();
    chk("reraised_strike", 32'(strike_count), 32'd1);
    bus.strike_in = 4'b0000; tick();
    bus.strike_in = 4'b0101; tick();
    chk("double_strike",  32'(strike_count), 32'd3);
    chk("double_explode", 32'(exploded),     32'd1);
    bus.strike_in = 4'b0000;
    one_hz_enable = 1'b1;
    repeat (2) tick();
    one_hz_enable = 1'b0;

    // Game 2: strike limit and full defuse in the same cycle.
    play_start();
    repeat (8) tick();
    bus.strike_in = 4'b0010; tick();
    bus.strike_in = 4'b0110; tick();
    chk("two_strikes", 32'(strike_count), 32'd2);
    bus.strike_in  = 4'b1110;
    bus.defused_in = 4'b1111;
    tick();
    chk("tie_exploded", 32'(exploded), 32'd1);
    chk("tie_defused",  32'(defused),  32'd0);
    bus.defused_in = '0;
    bus.strike_in  = '0;
    tick();

    // Game 3: clean defuse after one second.
    play_start();
    repeat (8) tick();
    one_hz_enable = 1'b1; tick();
    one_hz_enable = 1'b0;
    bus.defused_in = 4'b1111; tick();
    chk("defuse_flag",    32'(defused),      32'd1);
    chk("defuse_seconds", 32'(seconds_left), 32'd299);
    bus.defused_in = '0;
    tick();

    // Game 4: countdown to zero, then extra pulses leave it at zero.
    play_start();
    repeat (8) tick();
    one_hz_enable = 1'b1;
    repeat (START) tick();
    chk("timeout_explode", 32'(exploded),     32'd1);
    chk("timeout_zero",    32'(seconds_left), 32'd0);
    repeat (3) tick();
    chk("timeout_floor",   32'(seconds_left), 32'd0);
    one_hz_enable = 1'b0;

    // Reset during seeding, then a fresh start reseeds from module 0.
    play_start();
    repeat (2) tick();
    reset_n = 1'b0; tick();
    chk("abort_version", 32'(bus.version_out),  32'd0);
    chk("abort_mreset",  32'(bus.module_reset), 32'd1);
    chk("abort_rng",     32'(bus.rng_enable),   32'd0);
    reset_n = 1'b1; tick();
    play_start();
    chk("reseed_rng", 32'(bus.rng_enable), 32'd1);
    repeat (8) tick();
    chk("reseed_armed", 32'(armed), 32'd1);

    // Randomized play against the reference model.
    for (int k = 0; k < 4000; k++) begin
      reset_n       = ($urandom_range(0, 299) != 0);
      start         = ($urandom_range(0, 24) == 0);
      one_hz_enable = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, NM - 1));
        bus.strike_in[b] = ~bus.strike_in[b];
      end
      bus.defused_in = ($urandom_range(0, 39) == 0) ? {NM{1'b1}} : NM'($urandom_range(0, 14));
      tick();
    end

    reset_n = 1'b1;
    start   = 1'b0;
    tick();
    #10;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
